// File: rtl/multi_lane_data_selector_if.sv
// Tile-reader beat and row-router channel bundle for multi_lane_data_selector.
// o_hit_cnt exists only when DS_HIT_CNT_EN is defined.
interface multi_lane_data_selector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 64,
    parameter int S_HEIGHT   = 4,
    parameter int LANES      = 2,
    parameter int CNT_WIDTH  = 16
);
    localparam int ADDR_WIDTH = $clog2(BUF_DEPTH);

    logic                            i_tr_valid;
    logic                            o_tr_ready;
    logic [ADDR_WIDTH-1:0]           i_tr_base_addr;
    logic [LANES-1:0]                i_tr_lane_valid;
    logic [LANES*DATA_WIDTH-1:0]     i_tr_data;
    logic [S_HEIGHT-1:0]             i_rr_addr_valid;
    logic [S_HEIGHT*ADDR_WIDTH-1:0]  i_rr_addr;
    logic [S_HEIGHT-1:0]             o_rr_addr_pop;
    logic [S_HEIGHT*DATA_WIDTH-1:0]  o_rr_data;
    logic [S_HEIGHT-1:0]             o_rr_data_valid;
    logic [S_HEIGHT-1:0]             i_rr_data_ready;
`ifdef DS_HIT_CNT_EN
    logic [S_HEIGHT*CNT_WIDTH-1:0]   o_hit_cnt;
`endif

    modport slave (
        input  i_tr_valid, i_tr_base_addr, i_tr_lane_valid, i_tr_data,
        input  i_rr_addr_valid, i_rr_addr, i_rr_data_ready,
`ifdef DS_HIT_CNT_EN
        output o_hit_cnt,
`endif
        output o_tr_ready, o_rr_addr_pop, o_rr_data, o_rr_data_valid
    );

    modport master (
        output i_tr_valid, i_tr_base_addr, i_tr_lane_valid, i_tr_data,
        output i_rr_addr_valid, i_rr_addr, i_rr_data_ready,
`ifdef DS_HIT_CNT_EN
        input  o_hit_cnt,
`endif
        input  o_tr_ready, o_rr_addr_pop, o_rr_data, o_rr_data_valid
    );
endinterface

// File: rtl/multi_lane_data_selector.sv
// Routes lanes of a tile-reader beat to every row whose head address matches; optional hit counters (DS_HIT_CNT_EN).
// Latency: 1 clk beat -> o_rr_data_valid; pop is combinational in the accept cycle.
// Backpressure: a beat is held whole while any matching row output register is full and not draining.
module multi_lane_data_selector #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 64,
    parameter int S_HEIGHT   = 4,
    parameter int LANES      = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_stall_en,
    input  logic i_reg_clear,
    multi_lane_data_selector_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(BUF_DEPTH);
    localparam int AW1        = ADDR_WIDTH + 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} row_state_t;

    logic [LANES-1:0]                     w_live;
    logic [LANES-1:0][AW1-1:0]            w_lane_addr;
    logic [S_HEIGHT-1:0]                  w_match;
    logic [S_HEIGHT-1:0]                  w_can_take;
    logic [S_HEIGHT-1:0]                  w_commit;
    logic [S_HEIGHT-1:0]                  w_valid;
    logic                                 w_tr_ready;
    logic [S_HEIGHT-1:0][DATA_WIDTH-1:0]  w_sel_data;
    logic [S_HEIGHT-1:0][DATA_WIDTH-1:0]  r_data;
    row_state_t                           r_state [S_HEIGHT];

    // Extra address bit lets lanes past the buffer end be rejected instead of wrapping.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_lane_addr[k] = {1'b0, bus.i_tr_base_addr} + AW1'(k);
            w_live[k]      = bus.i_tr_lane_valid[k] && (w_lane_addr[k] < AW1'(BUF_DEPTH));
        end
    end

    // Descending scan so the lowest matching lane is the one left standing.
    always_comb begin
        w_match    = '0;
        w_sel_data = '0;
        for (int r = 0; r < S_HEIGHT; r++) begin
            for (int k = LANES - 1; k >= 0; k--) begin
                if (w_live[k] && (w_lane_addr[k] == {1'b0, bus.i_rr_addr[r*ADDR_WIDTH +: ADDR_WIDTH]})) begin
                    w_match[r]    = 1'b1;
                    w_sel_data[r] = bus.i_tr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            w_match[r] = w_match[r] & i_en & bus.i_tr_valid & bus.i_rr_addr_valid[r];
        end
    end

    always_comb begin
        for (int r = 0; r < S_HEIGHT; r++) begin
            w_valid[r] = (r_state[r] == FULL);
        end
    end

    assign w_can_take = ~w_valid | bus.i_rr_data_ready;
    assign w_tr_ready = i_en & ~i_stall_en & ~i_reg_clear & ~|(w_match & ~w_can_take);
    assign w_commit   = w_match & {S_HEIGHT{bus.i_tr_valid & w_tr_ready}};

    assign bus.o_tr_ready      = w_tr_ready;
    assign bus.o_rr_addr_pop   = w_commit;
    assign bus.o_rr_data       = r_data;
    assign bus.o_rr_data_valid = w_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < S_HEIGHT; r++) r_state[r] <= EMPTY;
            r_data <= '0;
        end else if (i_reg_clear) begin
            for (int r = 0; r < S_HEIGHT; r++) r_state[r] <= EMPTY;
            r_data <= '0;
        end else begin
            for (int r = 0; r < S_HEIGHT; r++) begin
                if (w_commit[r]) begin
                    r_state[r] <= FULL;
                    r_data[r]  <= w_sel_data[r];
                end else if (bus.i_rr_data_ready[r]) begin
                    r_state[r] <= EMPTY;
                end
            end
        end
    end

`ifdef DS_HIT_CNT_EN
    logic [S_HEIGHT-1:0][CNT_WIDTH-1:0] r_hit_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit_cnt <= '0;
        end else if (i_reg_clear) begin
            r_hit_cnt <= '0;
        end else begin
            for (int r = 0; r < S_HEIGHT; r++) begin
                if (w_commit[r] && (r_hit_cnt[r] != {CNT_WIDTH{1'b1}})) begin
                    r_hit_cnt[r] <= r_hit_cnt[r] + 1'b1;
                end
            end
        end
    end

    assign bus.o_hit_cnt = r_hit_cnt;
`endif
endmodule
